dds_wavegen: RTL and testbench
==============================

DDS_WAVEGEN -- requirements
Module: dds_wavegen

Interface
REQ-001 SHALL have parameter PHASE_W, default 24: phase accumulator width.
REQ-002 SHALL have parameter DATA_W, default 8: sample width, unsigned offset-binary.
REQ-003 SHALL have parameter LUT_AW, default 7: quarter-wave sine table address width (2^LUT_AW entries).
REQ-004 SHALL have parameter FTW_RESET, default 24'd65536: tuning word loaded at reset.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 en  in  1  accumulate enable.
REQ-009 ftw_in  in  PHASE_W  new frequency tuning word.
REQ-010 ftw_valid  in  1  load strobe for ftw_in.
REQ-011 wave_sel  in  2  requested waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-012 amp  in  DATA_W  amplitude scale.
REQ-013 wave_out  out  DATA_W  scaled sample.
REQ-014 out_valid  out  1  wave_out holds a real sample.
REQ-015 sync  out  1  one-cycle marker of the first sample after phase wrap.
REQ-016 wave_active  out  2  waveform currently generated.
REQ-017 seg_wave  out  7  active-low seven-segment code of wave_active.

Function
REQ-018 Phase: when en=1, phase <= (phase + ftw_active) mod 2^PHASE_W each cycle; when en=0, phase, pipeline and all outputs hold.
REQ-019 ftw_valid=1 SHALL load ftw_in into ftw_active at that edge; first accumulation with the new word occurs next cycle; no phase reset (phase-continuous).
REQ-020 wave_sel SHALL be latched as pending each cycle; pending SHALL transfer to wave_active only on an accumulation that carries out of the phase MSB (wrap); no change mid-period.
REQ-021 Waveform from p = top DATA_W bits of phase: sawtooth = p; square = all-ones if p MSB=0 else 0; triangle = {p[DATA_W-2:0],0} if MSB=0 else bitwise inverse of it; sine = quarter-wave lookup mirrored in address by phase bit MSB-1 and inverted about mid-scale by phase MSB.
REQ-022 Scaling: wave_out = (raw * (amp+1)) >> DATA_W, computed at 2*DATA_W+1 bits, no overflow; amp=all-ones passes raw unchanged; amp=0 yields raw>>DATA_W (=0).
REQ-023 Pipeline: phase register -> raw sample register -> scaled register; wave_out lags phase by 2 enabled cycles; total 3 enabled cycles from a phase value to its output.
REQ-024 out_valid SHALL rise after 3 enabled cycles following reset and stay high until reset.
REQ-025 sync SHALL pulse high for exactly one cycle, aligned with the wave_out sample of the wrapping accumulation; simultaneous wrap and wave change: sync sample already uses the new waveform.
REQ-026 ftw_active=0 SHALL freeze phase yet keep pipeline updating (constant output, no sync).
REQ-027 seg_wave: 0->1000000, 1->1111001, 2->0100100, 3->0110000, registered from wave_active.

Reset
REQ-028 On rst=1 at a clock edge: phase=0, ftw_active=FTW_RESET, wave_active=0, pending=0, wave_out=0, out_valid=0, sync=0, seg_wave=1000000; rst overrides en and ftw_valid.
REQ-029 Reset mid-period SHALL discard pipeline contents; restart behaves as from power-up.

Configuration
REQ-030 Macro DDS_WAVEGEN_SEG_EN: defined -> seg_wave driven per REQ-027; undefined -> seg_wave constant 1111111 (blank), decoder logic absent; port always present.

Structure
REQ-031 Package dds_pkg SHALL hold the waveform-select enum, the seven-segment code constants and the waveform-mode count.
REQ-032 Quarter-wave table SHALL be sub-module dds_sine_lut (registered read, one-cycle, address LUT_AW, data DATA_W-1 magnitude), forming the raw stage for sine.

Verification
REQ-033 Reset, en=1, ftw=FTW_RESET, sawtooth, amp=255 -> wave_out increments by 1 every cycle after latency 3, sync every 256 cycles, out_valid at cycle 3.
REQ-034 Square, ftw=2^22 -> wave_out 255 for 2 samples then 0 for 2 samples, period 4; amp=127 -> 127/0.
REQ-035 Switch wave_sel 3->2 mid-period -> wave_active and seg_wave change only at next wrap; sync sample shows triangle; seg 0110000->0100100.
REQ-036 ftw_valid with ftw_in=2*FTW_RESET mid-period -> no phase jump, step doubles from next cycle.
REQ-037 Sine, ftw=2^16, amp=255 -> samples at quarter points 128±1, 255±1, 128±1, 0±1; en=0 for 5 cycles -> outputs frozen.
REQ-038 rst asserted mid-run with ftw_valid=1 -> all outputs at reset values, ftw_active=FTW_RESET.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared waveform-select encoding and seven-segment display codes for the DDS waveform generator.
package dds_pkg;

   localparam int unsigned WAVE_COUNT = 4;

   typedef enum logic [$clog2(WAVE_COUNT)-1:0] {
      WAVE_SINE   = 2'd0,
      WAVE_SQUARE = 2'd1,
      WAVE_TRI    = 2'd2,
      WAVE_SAW    = 2'd3
   } wave_e;

   // Active-low segment codes, bit 6 = segment g ... bit 0 = segment a
   localparam logic [6:0] SEG_SINE   = 7'b1000000;
   localparam logic [6:0] SEG_SQUARE = 7'b1111001;
   localparam logic [6:0] SEG_TRI    = 7'b0100100;
   localparam logic [6:0] SEG_SAW    = 7'b0110000;
   localparam logic [6:0] SEG_BLANK  = 7'b1111111;

   function automatic logic [6:0] seg_code(input wave_e w);
      case (w)
         WAVE_SINE:   seg_code = SEG_SINE;
         WAVE_SQUARE: seg_code = SEG_SQUARE;
         WAVE_TRI:    seg_code = SEG_TRI;
         WAVE_SAW:    seg_code = SEG_SAW;
         default:     seg_code = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Quarter-wave sine magnitude table with a registered, enable-gated read port.
module dds_sine_lut #(
   parameter int unsigned LUT_AW = 7,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [LUT_AW-1:0] addr,
   output logic [DATA_W-2:0] mag
);

   localparam int unsigned DEPTH = 2 ** LUT_AW;

   // Entry i = full-scale * sin(pi/2 * i/DEPTH), via Bhaskara's rational approximation
   // so the table folds to constants without real arithmetic.
   function automatic logic [DATA_W-2:0] sine_entry(input int unsigned idx);
      longint unsigned a, d, span, full, num, den;
      a    = 64'(idx);
      d    = 64'(2 * DEPTH);
      span = a * (d - a);
      full = (64'd1 << (DATA_W - 1)) - 64'd1;
      num  = 64'd16 * span * full;
      den  = 64'd5 * d * d - 64'd4 * span;
      return (DATA_W-1)'((64'd2 * num + den) / (64'd2 * den));
   endfunction

   logic [DATA_W-2:0] rom [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_rom
      assign rom[g] = sine_entry(g);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mag <= '0;
      end else if (en) begin
         mag <= rom[addr];
      end
   end

endmodule

// File: rtl/dds_wavegen.sv
// Phase-accumulator waveform generator: phase -> raw sample -> amplitude-scaled output.
// Define DDS_WAVEGEN_SEG_EN to drive seg_wave from the active waveform; otherwise it is blank.
module dds_wavegen
   import dds_pkg::*;
#(
   parameter int unsigned        PHASE_W   = 24,
   parameter int unsigned        DATA_W    = 8,
   parameter int unsigned        LUT_AW    = 7,
   parameter logic [PHASE_W-1:0] FTW_RESET = 24'd65536
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PHASE_W-1:0] ftw_in,
   input  logic               ftw_valid,
   input  logic [1:0]         wave_sel,
   input  logic [DATA_W-1:0]  amp,
   output logic [DATA_W-1:0]  wave_out,
   output logic               out_valid,
   output logic               sync,
   output logic [1:0]         wave_active,
   output logic [6:0]         seg_wave
);

   logic [PHASE_W-1:0]  phase;
   logic [PHASE_W-1:0]  ftw_active;
   logic [PHASE_W:0]    phase_sum;
   logic                wrap;
   wave_e               wave_pending;
   wave_e               wave_active_q;
   logic                wrap_q;

   logic [DATA_W-1:0]   p;
   logic [DATA_W-1:0]   raw_calc;
   logic [DATA_W-1:0]   raw_q;
   logic [DATA_W-1:0]   raw;
   logic [LUT_AW-1:0]   lut_addr;
   logic [DATA_W-2:0]   sine_mag;
   logic                sine_q;
   logic                sine_neg_q;
   logic                wrap_raw_q;

   logic [DATA_W:0]     amp_inc;
   logic [2*DATA_W:0]   product;
   logic [2:0]          valid_sr;
   logic                unused_bits;

   assign phase_sum = {1'b0, phase} + {1'b0, ftw_active};
   assign wrap      = phase_sum[PHASE_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         phase         <= '0;
         ftw_active    <= FTW_RESET;
         wave_pending  <= WAVE_SINE;
         wave_active_q <= WAVE_SINE;
         wrap_q        <= 1'b0;
      end else begin
         wave_pending <= wave_e'(wave_sel);
         if (ftw_valid) begin
            ftw_active <= ftw_in;
         end
         if (en) begin
            phase  <= phase_sum[PHASE_W-1:0];
            wrap_q <= wrap;
            if (wrap) begin
               wave_active_q <= wave_pending;
            end
         end
      end
   end

   assign p = phase[PHASE_W-1 -: DATA_W];

   always_comb begin
      raw_calc = p;
      case (wave_active_q)
         WAVE_SQUARE: raw_calc = p[DATA_W-1] ? '0 : '1;
         WAVE_TRI:    raw_calc = p[DATA_W-1] ? ~{p[DATA_W-2:0], 1'b0} : {p[DATA_W-2:0], 1'b0};
         default:     raw_calc = p;
      endcase
   end

   // Second quadrant reads the table backwards; the half-cycle sign is applied after the read.
   assign lut_addr = phase[PHASE_W-2] ? ~phase[PHASE_W-3 -: LUT_AW] : phase[PHASE_W-3 -: LUT_AW];

   dds_sine_lut #(
      .LUT_AW (LUT_AW),
      .DATA_W (DATA_W)
   ) u_sine_lut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .addr (lut_addr),
      .mag  (sine_mag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         raw_q      <= '0;
         sine_q     <= 1'b0;
         sine_neg_q <= 1'b0;
         wrap_raw_q <= 1'b0;
      end else if (en) begin
         raw_q      <= raw_calc;
         sine_q     <= (wave_active_q == WAVE_SINE);
         sine_neg_q <= phase[PHASE_W-1];
         wrap_raw_q <= wrap_q;
      end
   end

   assign raw = sine_q ? {~sine_neg_q, (sine_neg_q ? ~sine_mag : sine_mag)} : raw_q;

   assign amp_inc     = {1'b0, amp} + {{DATA_W{1'b0}}, 1'b1};
   assign product     = {{(DATA_W+1){1'b0}}, raw} * {{DATA_W{1'b0}}, amp_inc};
   assign unused_bits = ^{product[2*DATA_W], product[DATA_W-1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         wave_out <= '0;
         sync     <= 1'b0;
         valid_sr <= '0;
      end else if (en) begin
         wave_out <= product[2*DATA_W-1:DATA_W];
         sync     <= wrap_raw_q;
         valid_sr <= {valid_sr[1:0], 1'b1};
      end else begin
         sync <= 1'b0;
      end
   end

   assign out_valid   = valid_sr[2];
   assign wave_active = wave_active_q;

`ifdef DDS_WAVEGEN_SEG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_wave <= SEG_SINE;
      end else begin
         seg_wave <= seg_code(wave_active_q);
      end
   end
`else
   assign seg_wave = SEG_BLANK;
`endif

endmodule

// File: tb/tb_dds_wavegen.sv
// Directed self-checking bench for dds_wavegen (default parameters).
`timescale 1ns/1ps
module tb_dds_wavegen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [23:0] ftw_in;
   logic        ftw_valid;
   logic [1:0]  wave_sel;
   logic [7:0]  amp;
   logic [7:0]  wave_out;
   logic        out_valid;
   logic        sync;
   logic [1:0]  wave_active;
   logic [6:0]  seg_wave;

   int tests_run    = 0;
   int tests_failed = 0;

   localparam logic [6:0] EXP_SEG_SINE  = 7'b1000000;
   localparam logic [6:0] EXP_SEG_TRI   = 7'b0100100;
   localparam logic [6:0] EXP_SEG_SAW   = 7'b0110000;
   localparam logic [6:0] EXP_SEG_BLANK = 7'b1111111;

   dds_wavegen #(
      .PHASE_W   (24),
      .DATA_W    (8),
      .LUT_AW    (7),
      .FTW_RESET (24'd65536)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .ftw_in      (ftw_in),
      .ftw_valid   (ftw_valid),
      .wave_sel    (wave_sel),
      .amp         (amp),
      .wave_out    (wave_out),
      .out_valid   (out_valid),
      .sync        (sync),
      .wave_active (wave_active),
      .seg_wave    (seg_wave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] wsel);
      rst = 1'b1; en = 1'b0; ftw_valid = 1'b0; ftw_in = '0; wave_sel = wsel; amp = 8'd255;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(2'd0);
      tests_run++;
      if (wave_out !== 8'd0) begin tests_failed++; $display("FAIL reset_wave_out: got %0d expected 0", wave_out); end
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests_run++;
      if (sync !== 1'b0) begin tests_failed++; $display("FAIL reset_sync: got %b expected 0", sync); end
      tests_run++;
      if (wave_active !== 2'd0) begin tests_failed++; $display("FAIL reset_wave_active: got %0d expected 0", wave_active); end
      tests_run++;
`ifdef DDS_WAVEGEN_SEG_EN
      if (seg_wave !== EXP_SEG_SINE) begin tests_failed++; $display("FAIL reset_seg: got %b expected %b", seg_wave, EXP_SEG_SINE); end
`else
      if (seg_wave !== EXP_SEG_BLANK) begin tests_failed++; $display("FAIL reset_seg: got %b expected %b", seg_wave, EXP_SEG_BLANK); end
`endif
   endtask

   task automatic test_sawtooth();
      int bad = 0;
      int bad_n = 0;
      logic [7:0] bad_val = '0;
      int sync_cnt = 0;
      int sync_a = -1;
      int sync_b = -1;
      do_reset(2'd3);
      en = 1'b1;
      for (int n = 1; n <= 514; n++) begin
         step();
         if (n == 2) begin
            tests_run++;
            if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL saw_valid_c2: got %b expected 0", out_valid); end
         end
         if (n == 3) begin
            tests_run++;
            if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL saw_valid_c3: got %b expected 1", out_valid); end
         end
         if (n == 255) begin
            tests_run++;
            if (wave_active !== 2'd0) begin tests_failed++; $display("FAIL saw_active_prewrap: got %0d expected 0", wave_active); end
         end
         if (n == 256) begin
            tests_run++;
            if (wave_active !== 2'd3) begin tests_failed++; $display("FAIL saw_active_wrap: got %0d expected 3", wave_active); end
         end
         if (n >= 258 && (wave_out !== 8'((n - 2) % 256) || out_valid !== 1'b1)) begin
            if (bad == 0) begin bad_n = n; bad_val = wave_out; end
            bad++;
         end
         if (n >= 3 && sync === 1'b1) begin
            sync_cnt++;
            if (sync_a < 0) sync_a = n; else if (sync_b < 0) sync_b = n;
         end
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL saw_ramp: %0d bad samples, first at cycle %0d got %0d expected %0d", bad, bad_n, bad_val, (bad_n - 2) % 256);
      end
      tests_run++;
      if (sync_cnt !== 2 || sync_a !== 258 || sync_b !== 514) begin
         tests_failed++;
         $display("FAIL saw_sync: got %0d pulses at %0d,%0d expected 2 pulses at 258,514", sync_cnt, sync_a, sync_b);
      end
   endtask

   task automatic test_square();
      logic [7:0] exp_w;
      logic       exp_s;
      do_reset(2'd1);
      ftw_valid = 1'b1; ftw_in = 24'h400000;
      step();
      ftw_valid = 1'b0; en = 1'b1;
      for (int n = 1; n <= 17; n++) begin
         step();
         if (n >= 6) begin
            exp_w = (((n - 6) % 4) < 2) ? ((n >= 14) ? 8'd127 : 8'd255) : 8'd0;
            tests_run++;
            if (wave_out !== exp_w) begin tests_failed++; $display("FAIL square_c%0d: got %0d expected %0d", n, wave_out, exp_w); end
         end
         if (n >= 3) begin
            exp_s = (n >= 6) && ((n % 4) == 2);
            tests_run++;
            if (sync !== exp_s) begin tests_failed++; $display("FAIL square_sync_c%0d: got %b expected %b", n, sync, exp_s); end
         end
         if (n == 13) amp = 8'd127;
      end
   endtask

   task automatic test_switch();
      do_reset(2'd3);
      ftw_valid = 1'b1; ftw_in = 24'h100000;
      step();
      ftw_valid = 1'b0; en = 1'b1;
      for (int n = 1; n <= 35; n++) begin
         step();
         case (n)
            15: begin
               tests_run++;
               if (wave_active !== 2'd0) begin tests_failed++; $display("FAIL sw_active_c15: got %0d expected 0", wave_active); end
            end
            16: begin
               tests_run++;
               if (wave_active !== 2'd3) begin tests_failed++; $display("FAIL sw_active_c16: got %0d expected 3", wave_active); end
            end
`ifdef DDS_WAVEGEN_SEG_EN
            17: begin
               tests_run++;
               if (seg_wave !== EXP_SEG_SAW) begin tests_failed++; $display("FAIL sw_seg_c17: got %b expected %b", seg_wave, EXP_SEG_SAW); end
            end
`endif
            20: wave_sel = 2'd2;
            31: begin
               tests_run++;
               if (wave_active !== 2'd3) begin tests_failed++; $display("FAIL sw_active_mid: got %0d expected 3", wave_active); end
            end
            32: begin
               tests_run++;
               if (wave_active !== 2'd2) begin tests_failed++; $display("FAIL sw_active_c32: got %0d expected 2", wave_active); end
`ifdef DDS_WAVEGEN_SEG_EN
               tests_run++;
               if (seg_wave !== EXP_SEG_SAW) begin tests_failed++; $display("FAIL sw_seg_c32: got %b expected %b", seg_wave, EXP_SEG_SAW); end
`endif
            end
            33: begin
               tests_run++;
               if (wave_out !== 8'd240 || sync !== 1'b0) begin tests_failed++; $display("FAIL sw_last_saw: got %0d/%b expected 240/0", wave_out, sync); end
               tests_run++;
`ifdef DDS_WAVEGEN_SEG_EN
               if (seg_wave !== EXP_SEG_TRI) begin tests_failed++; $display("FAIL sw_seg_c33: got %b expected %b", seg_wave, EXP_SEG_TRI); end
`else
               if (seg_wave !== EXP_SEG_BLANK) begin tests_failed++; $display("FAIL sw_seg_c33: got %b expected %b", seg_wave, EXP_SEG_BLANK); end
`endif
            end
            34: begin
               tests_run++;
               if (wave_out !== 8'd0 || sync !== 1'b1) begin tests_failed++; $display("FAIL sw_sync_sample: got %0d/%b expected 0/1", wave_out, sync); end
            end
            35: begin
               tests_run++;
               if (wave_out !== 8'd32 || sync !== 1'b0) begin tests_failed++; $display("FAIL sw_first_tri: got %0d/%b expected 32/0", wave_out, sync); end
            end
            default: ;
         endcase
      end
   endtask

   task automatic test_ftw_change();
      logic [7:0] exp_w;
      do_reset(2'd3);
      en = 1'b1;
      for (int n = 1; n <= 315; n++) begin
         step();
         exp_w = 8'd0;
         case (n)
            300: exp_w = 8'd42;
            301: exp_w = 8'd43;
            302: exp_w = 8'd44;
            303: exp_w = 8'd46;
            304: exp_w = 8'd48;
            305: exp_w = 8'd50;
            306: exp_w = 8'd0;
            307: exp_w = 8'd54;
            308: exp_w = 8'd56;
            default: exp_w = 8'd58;
         endcase
         if (n >= 300) begin
            tests_run++;
            if (wave_out !== exp_w) begin tests_failed++; $display("FAIL ftw_c%0d: got %0d expected %0d", n, wave_out, exp_w); end
         end
         if (n >= 308) begin
            tests_run++;
            if (sync !== 1'b0) begin tests_failed++; $display("FAIL ftw_zero_sync_c%0d: got %b expected 0", n, sync); end
         end
         case (n)
            299: begin ftw_valid = 1'b1; ftw_in = 24'd131072; end
            300: ftw_valid = 1'b0;
            305: amp = 8'd0;
            306: begin amp = 8'd255; ftw_valid = 1'b1; ftw_in = 24'd0; end
            307: ftw_valid = 1'b0;
            default: ;
         endcase
      end
   endtask

   task automatic test_sine();
      do_reset(2'd0);
      en = 1'b1;
      for (int n = 1; n <= 258; n++) begin
         step();
         if (n == 66) begin
            tests_run++;
            if (wave_out < 8'd254) begin tests_failed++; $display("FAIL sine_q1: got %0d expected 255+-1", wave_out); end
            en = 1'b0;
            for (int k = 0; k < 5; k++) begin
               step();
               tests_run++;
               if (wave_out < 8'd254 || out_valid !== 1'b1 || sync !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL sine_freeze_%0d: got %0d/%b/%b expected 255+-1/1/0", k, wave_out, out_valid, sync);
               end
            end
            en = 1'b1;
         end
         if (n == 130) begin
            tests_run++;
            if (wave_out < 8'd127 || wave_out > 8'd129) begin tests_failed++; $display("FAIL sine_q2: got %0d expected 128+-1", wave_out); end
         end
         if (n == 194) begin
            tests_run++;
            if (wave_out > 8'd1) begin tests_failed++; $display("FAIL sine_q3: got %0d expected 0+-1", wave_out); end
         end
         if (n == 257) begin
            tests_run++;
            if (sync !== 1'b0) begin tests_failed++; $display("FAIL sine_sync_early: got %b expected 0", sync); end
         end
         if (n == 258) begin
            tests_run++;
            if (wave_out < 8'd127 || wave_out > 8'd129 || sync !== 1'b1) begin
               tests_failed++;
               $display("FAIL sine_q0: got %0d/%b expected 128+-1/1", wave_out, sync);
            end
         end
      end
   endtask

   task automatic test_reset_midrun();
      do_reset(2'd3);
      en = 1'b1;
      repeat (40) step();
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_prerun_valid: got %b expected 1", out_valid); end
      rst = 1'b1; ftw_valid = 1'b1; ftw_in = 24'h123456; wave_sel = 2'd2;
      step();
      tests_run++;
      if (wave_out !== 8'd0 || out_valid !== 1'b0 || sync !== 1'b0 || wave_active !== 2'd0) begin
         tests_failed++;
         $display("FAIL mid_reset_outputs: got %0d/%b/%b/%0d expected 0/0/0/0", wave_out, out_valid, sync, wave_active);
      end
      tests_run++;
`ifdef DDS_WAVEGEN_SEG_EN
      if (seg_wave !== EXP_SEG_SINE) begin tests_failed++; $display("FAIL mid_reset_seg: got %b expected %b", seg_wave, EXP_SEG_SINE); end
`else
      if (seg_wave !== EXP_SEG_BLANK) begin tests_failed++; $display("FAIL mid_reset_seg: got %b expected %b", seg_wave, EXP_SEG_BLANK); end
`endif
      rst = 1'b0; ftw_valid = 1'b0; wave_sel = 2'd3;
      for (int n = 1; n <= 256; n++) begin
         step();
         if (n == 1) begin
            tests_run++;
            if (wave_out !== 8'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_restart_c1: got %0d/%b expected 0/0", wave_out, out_valid); end
         end
         if (n == 2) begin
            tests_run++;
            if (wave_out !== 8'd128 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_restart_c2: got %0d/%b expected 128/0", wave_out, out_valid); end
         end
         if (n == 3) begin
            tests_run++;
            if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_restart_valid: got %b expected 1", out_valid); end
         end
         if (n == 255) begin
            tests_run++;
            if (wave_active !== 2'd0) begin tests_failed++; $display("FAIL mid_ftw_prewrap: got %0d expected 0", wave_active); end
         end
         if (n == 256) begin
            tests_run++;
            if (wave_active !== 2'd3) begin tests_failed++; $display("FAIL mid_ftw_wrap: got %0d expected 3", wave_active); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; ftw_valid = 1'b0; ftw_in = '0; wave_sel = 2'd0; amp = 8'd255;
      test_reset();
      test_sawtooth();
      test_square();
      test_switch();
      test_ftw_change();
      test_sine();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
